pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Merges per-stage stall requests, owns the multi-cycle divider busy counter, and sequences exception/ERET and branch-mispredict flushes.
- Drives the per-stage stall/flush vectors consumed by every inter-stage pipeline register, plus the fetch redirect.

---
 rtl/pipeline_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: stall merge, divider busy counter,
// exception/ERET and branch flush sequencing. Optional perf counters under PIPE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned PC_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallreq_if,
    input  logic            stallreq_id,
    input  logic            stallreq_mem,
    input  logic            div_start,
    input  logic            br_flush,
    input  logic [PC_W-1:0] br_target,
    input  logic            exc_req,
    input  logic [PC_W-1:0] exc_vec,
    input  logic            eret_req,
    input  logic [PC_W-1:0] epc,
    output logic [4:0]      stall,
    output logic [4:0]      flush,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            div_busy,
    output logic            div_ready,
    output logic            br_ack,
    output logic            exc_ack,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM, S_FLUSH} state_t;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t          r_state, w_state_nxt;
    logic [5:0]      r_div_cnt;
    logic            r_div_busy, r_div_ready;
    logic [PC_W-1:0] r_exc_pc;
    logic [4:0]      w_stall_raw, w_stall_pre;
    logic            w_exc_any;

    assign w_exc_any = exc_req | eret_req;

    // Highest requesting stage wins; everything upstream of it is held too.
    always_comb begin
        w_stall_raw = '0;
        if (stallreq_mem)     w_stall_raw = 5'b01111;
        else if (r_div_busy)  w_stall_raw = 5'b00111;
        else if (stallreq_id) w_stall_raw = 5'b00011;
        else if (stallreq_if) w_stall_raw = 5'b00001;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_stall_pre    = w_stall_raw;
        flush          = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        br_ack         = 1'b0;
        exc_ack        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_exc_any) begin
                    w_state_nxt = stallreq_mem ? S_WAIT_MEM : S_FLUSH;
                end else if (br_flush && !w_stall_raw[2]) begin
                    flush          = 5'b00011;
                    redirect_valid = 1'b1;
                    redirect_pc    = br_target;
                    br_ack         = 1'b1;
                end
            end
            S_WAIT_MEM: begin
                w_stall_pre = 5'b01111;
                if (!stallreq_mem) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                w_stall_pre    = '0;
                flush          = 5'b01111;
                redirect_valid = 1'b1;
                redirect_pc    = r_exc_pc;
                exc_ack        = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        stall = w_stall_pre & ~flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_exc_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_exc_any)
                r_exc_pc <= exc_req ? exc_vec : epc;
        end
    end

    // The FLUSH cycle clears EX, which kills any divide in flight.
    always_ff @(posedge clk) begin
        if (rst || r_state == S_FLUSH) begin
            r_div_cnt   <= '0;
            r_div_busy  <= 1'b0;
            r_div_ready <= 1'b0;
        end else begin
            r_div_ready <= 1'b0;
            if (r_div_busy) begin
                if (r_div_cnt == '0) begin
                    r_div_busy  <= 1'b0;
                    r_div_ready <= 1'b1;
                end else begin
                    r_div_cnt <= r_div_cnt - 6'd1;
                end
            end else if (div_start) begin
                r_div_cnt  <= DIV_LOAD;
                r_div_busy <= 1'b1;
            end
        end
    end

    assign div_busy  = r_div_busy;
    assign div_ready = r_div_ready;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] r_perf_stall, r_perf_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (stall[0])         r_perf_stall <= r_perf_stall + 32'd1;
            if (br_ack || exc_ack) r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (DIV_CYCLES=4): vector table plus hand sequences,
// expectations queued at drive time and checked on the falling edge.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned PC_W = 32;
    localparam logic [31:0] BR = 32'h0040_0100;
    localparam logic [31:0] EV = 32'hBFC0_0380;
    localparam logic [31:0] EP = 32'h8000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_mem = 1'b0, div_start = 1'b0;
    logic br_flush = 1'b0, exc_req = 1'b0, eret_req = 1'b0;
    logic [PC_W-1:0] br_target = BR, exc_vec = EV, epc = EP;
    logic [4:0] stall, flush;
    logic redirect_valid, div_busy, div_ready, br_ack, exc_ack;
    logic [PC_W-1:0] redirect_pc;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    pipeline_hazard_ctrl #(.DIV_CYCLES(4), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_mem(stallreq_mem), .div_start(div_start), .br_flush(br_flush),
        .br_target(br_target), .exc_req(exc_req), .exc_vec(exc_vec), .eret_req(eret_req),
        .epc(epc), .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .div_busy(div_busy), .div_ready(div_ready),
        .br_ack(br_ack), .exc_ack(exc_ack), .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic       rst;
        logic [2:0] sreq;   // {mem, id, if}
        logic       ds, br, exc, eret;
        logic [4:0] stall, flush;
        logic [31:0] rpc;   // non-zero means redirect_valid expected
        logic       busy, rdy, back, eack;
    } vec_t;

    vec_t tbl[$];
    vec_t sbq[$];
    vec_t e;
    int   n_tests = 0, n_fail = 0, ntag = 0;
    logic [31:0] m_stall_cnt = 0, m_flush_cnt = 0;
    logic [9:0]  exp_bits, act_bits;

    function automatic vec_t v(input logic r, input logic [2:0] sq, input logic d, input logic b,
                               input logic x, input logic er, input logic [4:0] st,
                               input logic [4:0] fl, input logic [31:0] pc, input logic bz,
                               input logic rd, input logic ba, input logic ea);
        vec_t t;
        t.tag = 0; t.rst = r; t.sreq = sq; t.ds = d; t.br = b; t.exc = x; t.eret = er;
        t.stall = st; t.flush = fl; t.rpc = pc; t.busy = bz; t.rdy = rd; t.back = ba; t.eack = ea;
        return t;
    endfunction

    task automatic drive(input vec_t x);
        @(posedge clk);
        #1;
        rst = x.rst;
        {stallreq_mem, stallreq_id, stallreq_if} = x.sreq;
        div_start = x.ds; br_flush = x.br; exc_req = x.exc; eret_req = x.eret;
        x.tag = ntag;
        ntag++;
        sbq.push_back(x);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            exp_bits = {e.stall, e.flush[3:0] == 4'b0 ? 1'b0 : 1'b1, e.busy, e.rdy, e.back, e.eack};
            n_tests++;
            if (stall !== e.stall || flush !== e.flush || redirect_valid !== (e.rpc != 0) ||
                div_busy !== e.busy || div_ready !== e.rdy || br_ack !== e.back ||
                exc_ack !== e.eack) begin
                n_fail++;
                $display("FAIL vec%0d outputs: got stall=%b flush=%b rv=%b busy=%b rdy=%b back=%b eack=%b, want stall=%b flush=%b rv=%b busy=%b rdy=%b back=%b eack=%b",
                         e.tag, stall, flush, redirect_valid, div_busy, div_ready, br_ack, exc_ack,
                         e.stall, e.flush, (e.rpc != 0), e.busy, e.rdy, e.back, e.eack);
            end
            if (e.rpc != 0) begin
                n_tests++;
                if (redirect_pc !== e.rpc) begin
                    n_fail++;
                    $display("FAIL vec%0d redirect_pc: got %h want %h", e.tag, redirect_pc, e.rpc);
                end
            end
`ifdef PIPE_HAZARD_PERF_EN
            n_tests++;
            if (perf_stall_cnt !== m_stall_cnt || perf_flush_cnt !== m_flush_cnt) begin
                n_fail++;
                $display("FAIL vec%0d perf: got stall_cnt=%0d flush_cnt=%0d want %0d %0d",
                         e.tag, perf_stall_cnt, perf_flush_cnt, m_stall_cnt, m_flush_cnt);
            end
            if (e.rst) begin
                m_stall_cnt = 0;
                m_flush_cnt = 0;
            end else begin
                m_stall_cnt = m_stall_cnt + {31'd0, e.stall[0]};
                m_flush_cnt = m_flush_cnt + {31'd0, e.back | e.eack};
            end
`else
            n_tests++;
            if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
                n_fail++;
                $display("FAIL vec%0d perf_tieoff: got %0d %0d want 0 0",
                         e.tag, perf_stall_cnt, perf_flush_cnt);
            end
`endif
        end
    end

    initial begin
        // Basic table: reset, stall priority, divider, branch flush, ERET.
        tbl.push_back(v(1, 3'b000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 3'b000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 3'b100, 0, 0, 0, 0, 5'b01111, 5'b00000, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 3'b100, 0, 0, 0, 0, 5'b01111, 5'b00000, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 3'b100, 0, 0, 0, 0, 5'b01111, 5'b00000, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 3'b000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 3'b001, 0, 0, 0, 0, 5'b00001, 5'b00000, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 3'b010, 0, 0, 0, 0, 5'b00011, 5'b00000, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 3'b011, 0, 0, 0, 0, 5'b00011, 5'b00000, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 3'b000, 1, 0, 0, 0, 5'b00000, 5'b00000, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 3'b000, 1, 0, 0, 0, 5'b00111, 5'b00000, 0,  1, 0, 0, 0));
        tbl.push_back(v(0, 3'b000, 0, 0, 0, 0, 5'b00111, 5'b00000, 0,  1, 0, 0, 0));
        tbl.push_back(v(0, 3'b001, 0, 0, 0, 0, 5'b00111, 5'b00000, 0,  1, 0, 0, 0));
        tbl.push_back(v(0, 3'b100, 0, 0, 0, 0, 5'b01111, 5'b00000, 0,  1, 0, 0, 0));
        tbl.push_back(v(0, 3'b000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0,  0, 1, 0, 0));
        tbl.push_back(v(0, 3'b000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 3'b000, 0, 1, 0, 0, 5'b00000, 5'b00011, BR, 0, 0, 1, 0));
        tbl.push_back(v(0, 3'b100, 0, 1, 0, 0, 5'b01111, 5'b00000, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 3'b010, 0, 1, 0, 0, 5'b00000, 5'b00011, BR, 0, 0, 1, 0));
        tbl.push_back(v(0, 3'b000, 0, 0, 0, 1, 5'b00000, 5'b00000, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 3'b000, 0, 0, 0, 1, 5'b00000, 5'b01111, EP, 0, 0, 0, 1));
        tbl.push_back(v(0, 3'b000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0,  0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

        // Exception held behind a pending MEM access.
        drive(v(0, 3'b100, 0, 0, 1, 0, 5'b01111, 5'b00000, 0,  0, 0, 0, 0));
        drive(v(0, 3'b100, 0, 0, 1, 0, 5'b01111, 5'b00000, 0,  0, 0, 0, 0));
        drive(v(0, 3'b000, 0, 0, 1, 0, 5'b01111, 5'b00000, 0,  0, 0, 0, 0));
        drive(v(0, 3'b000, 0, 0, 1, 0, 5'b00000, 5'b01111, EV, 0, 0, 0, 1));
        drive(v(0, 3'b000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0,  0, 0, 0, 0));

        // Exception + branch while divider busy: exception wins, divide cancelled.
        drive(v(0, 3'b000, 1, 0, 0, 0, 5'b00000, 5'b00000, 0,  0, 0, 0, 0));
        drive(v(0, 3'b000, 0, 1, 1, 0, 5'b00111, 5'b00000, 0,  1, 0, 0, 0));
        drive(v(0, 3'b000, 0, 1, 1, 0, 5'b00000, 5'b01111, EV, 1, 0, 0, 1));
        for (int i = 0; i < 4; i++)
            drive(v(0, 3'b000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0));

        // Reset while in WAIT_MEM, then reset mid-divide.
        drive(v(0, 3'b100, 0, 0, 1, 0, 5'b01111, 5'b00000, 0,  0, 0, 0, 0));
        drive(v(0, 3'b100, 0, 0, 1, 0, 5'b01111, 5'b00000, 0,  0, 0, 0, 0));
        drive(v(1, 3'b000, 0, 0, 0, 0, 5'b01111, 5'b00000, 0,  0, 0, 0, 0));
        drive(v(0, 3'b000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0,  0, 0, 0, 0));
        drive(v(0, 3'b000, 1, 0, 0, 0, 5'b00000, 5'b00000, 0,  0, 0, 0, 0));
        drive(v(0, 3'b000, 0, 0, 0, 0, 5'b00111, 5'b00000, 0,  1, 0, 0, 0));
        drive(v(1, 3'b000, 0, 0, 0, 0, 5'b00111, 5'b00000, 0,  1, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            drive(v(0, 3'b000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0));

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
